// File: rtl/math_operand_driver.sv
// math_operand_driver: master-side companion to the math_core region.
// Takes one operand pair at a time from an upstream valid/ready stream,
// holds it stable at the core for CORE_LAT cycles, captures the core's
// result/statistic and offers them on a downstream valid/ready stream.
// A freeze input stops new work so the region can be reconfigured.
module math_operand_driver #(
  parameter int DATA_W   = 32,
  parameter int CORE_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ain,
  input  logic [DATA_W-1:0] in_bin,
  output logic [DATA_W-1:0] core_ain,
  output logic [DATA_W-1:0] core_bin,
  input  logic [DATA_W-1:0] core_result,
  input  logic [DATA_W-1:0] core_statistic,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_statistic,
  input  logic              freeze,
  output logic              idle,
  output logic [CNT_W-1:0]  txn_count
);

  // The wait counter only ever needs to hold CORE_LAT-1, and CORE_LAT tops out at 15.
  localparam int              LAT_W    = 4;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q;
  logic [LAT_W-1:0]    wait_q;
  logic [DATA_W-1:0]   ain_q;
  logic [DATA_W-1:0]   bin_q;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   statistic_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [LAT_W-1:0]    wait_d;

  // Next values for the two counters; the transaction count wraps silently.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    wait_d  = wait_q - LAT_W'(1);
  end

  // Transaction sequencer: accept, let operands settle, wait out the core latency, hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      ain_q       <= '0;
      bin_q       <= '0;
      result_q    <= '0;
      statistic_q <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            ain_q   <= in_ain;
            bin_q   <= in_bin;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wait_q  <= LAT_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == '0) begin
            result_q    <= core_result;
            statistic_q <= core_statistic;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            wait_q <= wait_d;
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            count_q     <= count_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Acceptance depends only on state and freeze so upstream never sees a loop through in_valid.
  always_comb begin
    in_ready = (state_q == IDLE) && !freeze;
    idle     = (state_q == IDLE);
  end

  assign core_ain      = ain_q;
  assign core_bin      = bin_q;
  assign out_valid     = out_valid_q;
  assign out_result    = result_q;
  assign out_statistic = statistic_q;
  assign txn_count     = count_q;

endmodule

// File: tb/tb_math_operand_driver.sv
// Testbench for math_operand_driver.
// Instance A: CORE_LAT=1, CNT_W=4, core modelled as registered max / xor.
// Instance B: CORE_LAT=4, CNT_W=16, core output changes every cycle so an
// early or late capture shows up as a wrong value.
module tb_math_operand_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A signals
  logic        ivA = 1'b0, irA, orA = 1'b0, ovA, frzA = 1'b0, idleA;
  logic [31:0] ainA = '0, binA = '0, cainA, cbinA, oresA, ostatA;
  logic [31:0] cresA = '0, cstatA = '0;
  logic [3:0]  cntA;

  // Instance B signals
  logic        ivB = 1'b0, irB, orB = 1'b0, ovB, frzB = 1'b0, idleB;
  logic [31:0] ainB = '0, binB = '0, cainB, cbinB, oresB, ostatB;
  logic [31:0] cresB, cstatB;
  logic [15:0] cntB;
  logic [31:0] cycB = '0;

  int nCmp = 0;
  int nFail = 0;
  int expCountA = 0;
  int expCountB = 0;

  math_operand_driver #(.DATA_W(32), .CORE_LAT(1), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst),
    .in_valid(ivA), .in_ready(irA), .in_ain(ainA), .in_bin(binA),
    .core_ain(cainA), .core_bin(cbinA),
    .core_result(cresA), .core_statistic(cstatA),
    .out_valid(ovA), .out_ready(orA),
    .out_result(oresA), .out_statistic(ostatA),
    .freeze(frzA), .idle(idleA), .txn_count(cntA)
  );

  math_operand_driver #(.DATA_W(32), .CORE_LAT(4), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst),
    .in_valid(ivB), .in_ready(irB), .in_ain(ainB), .in_bin(binB),
    .core_ain(cainB), .core_bin(cbinB),
    .core_result(cresB), .core_statistic(cstatB),
    .out_valid(ovB), .out_ready(orB),
    .out_result(oresB), .out_statistic(ostatB),
    .freeze(frzB), .idle(idleB), .txn_count(cntB)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] maxOf(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // Core model A: one-cycle registered max and xor.
  always @(posedge clk) begin
    cresA  <= maxOf(cainA, cbinA);
    cstatA <= cainA ^ cbinA;
  end

  // Core model B: output drifts with a cycle counter so capture timing is visible.
  always @(posedge clk) cycB <= cycB + 32'd1;
  assign cresB  = maxOf(cainB, cbinB) + cycB;
  assign cstatB = cycB;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1;
    ivA = 0; orA = 0; frzA = 0; ivB = 0; orB = 0; frzB = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expCountA = 0;
    expCountB = 0;
    nCmp++;
    if ({irA, idleA, ovA} !== 3'b110) begin
      nFail++; $display("[TB] FAIL reset_flags_A: got %b expected 110", {irA, idleA, ovA});
    end
    nCmp++;
    if ({oresA, ostatA, cainA, cbinA, cntA} !== '0) begin
      nFail++; $display("[TB] FAIL reset_data_A: got res=%h stat=%h ain=%h bin=%h cnt=%0d expected all 0",
                        oresA, ostatA, cainA, cbinA, cntA);
    end
    nCmp++;
    if ({irB, idleB, ovB, cntB} !== {3'b110, 16'd0}) begin
      nFail++; $display("[TB] FAIL reset_B: got ir=%b idle=%b ov=%b cnt=%0d expected 1 1 0 0",
                        irB, idleB, ovB, cntB);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    ainA = 32'd5; binA = 32'd9; ivA = 1'b1; orA = 1'b1;
    nCmp++;
    if (irA !== 1'b1) begin
      nFail++; $display("[TB] FAIL basic_in_ready: got %b expected 1", irA);
    end
    @(negedge clk);
    ivA = 1'b0;
    nCmp++;
    if ({cainA, cbinA, ovA, idleA} !== {32'd5, 32'd9, 1'b0, 1'b0}) begin
      nFail++; $display("[TB] FAIL basic_issue: got ain=%0d bin=%0d ov=%b idle=%b expected 5 9 0 0",
                        cainA, cbinA, ovA, idleA);
    end
    @(negedge clk);
    nCmp++;
    if (ovA !== 1'b0) begin
      nFail++; $display("[TB] FAIL basic_early_valid: got %b expected 0", ovA);
    end
    @(negedge clk);
    nCmp++;
    if ({ovA, oresA, ostatA} !== {1'b1, 32'd9, 32'd12}) begin
      nFail++; $display("[TB] FAIL basic_output: got ov=%b res=%0d stat=%0d expected 1 9 12", ovA, oresA, ostatA);
    end
    @(negedge clk);
    orA = 1'b0;
    expCountA++;
    nCmp++;
    if ({ovA, idleA, cntA} !== {1'b0, 1'b1, 4'(expCountA)}) begin
      nFail++; $display("[TB] FAIL basic_handoff: got ov=%b idle=%b cnt=%0d expected 0 1 %0d",
                        ovA, idleA, cntA, expCountA % 16);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    int w;
    a = $urandom; b = $urandom;
    @(negedge clk);
    ainA = a; binA = b; ivA = 1'b1; orA = 1'b0;
    @(negedge clk);
    ainA = $urandom; binA = $urandom;
    w = 0;
    while (ovA !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    nCmp++;
    if (ovA !== 1'b1) begin
      nFail++; $display("[TB] FAIL bp_wait_valid: got %b expected 1 within 10 cycles", ovA);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nCmp++;
      if ({ovA, irA, oresA, ostatA, cainA} !== {1'b1, 1'b0, maxOf(a, b), a ^ b, a}) begin
        nFail++; $display("[TB] FAIL bp_hold: cycle %0d got ov=%b ir=%b res=%h stat=%h ain=%h expected 1 0 %h %h %h",
                          i, ovA, irA, oresA, ostatA, cainA, maxOf(a, b), a ^ b, a);
      end
    end
    ivA = 1'b0; orA = 1'b1;
    @(negedge clk);
    orA = 1'b0;
    expCountA++;
    nCmp++;
    if ({ovA, idleA, cntA} !== {1'b0, 1'b1, 4'(expCountA)}) begin
      nFail++; $display("[TB] FAIL bp_handoff: got ov=%b idle=%b cnt=%0d expected 0 1 %0d",
                        ovA, idleA, cntA, expCountA % 16);
    end
    repeat (2) @(negedge clk);
    nCmp++;
    if (cntA !== 4'(expCountA)) begin
      nFail++; $display("[TB] FAIL bp_single_count: got %0d expected %0d", cntA, expCountA % 16);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] a1, b1, a2, b2;
    int w;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    ainA = a1; binA = b1; ivA = 1'b1; orA = 1'b0; frzA = 1'b0;
    @(negedge clk);
    ainA = a2; binA = b2;
    nCmp++;
    if ({cainA, irA} !== {a1, 1'b0}) begin
      nFail++; $display("[TB] FAIL frz_accept: got ain=%h ir=%b expected %h 0", cainA, irA, a1);
    end
    @(negedge clk);
    frzA = 1'b1;
    w = 0;
    while (ovA !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    nCmp++;
    if ({ovA, oresA, ostatA} !== {1'b1, maxOf(a1, b1), a1 ^ b1}) begin
      nFail++; $display("[TB] FAIL frz_complete: got ov=%b res=%h stat=%h expected 1 %h %h",
                        ovA, oresA, ostatA, maxOf(a1, b1), a1 ^ b1);
    end
    orA = 1'b1;
    @(negedge clk);
    orA = 1'b0;
    expCountA++;
    nCmp++;
    if ({ovA, idleA, irA, cntA} !== {1'b0, 1'b1, 1'b0, 4'(expCountA)}) begin
      nFail++; $display("[TB] FAIL frz_handoff: got ov=%b idle=%b ir=%b cnt=%0d expected 0 1 0 %0d",
                        ovA, idleA, irA, cntA, expCountA % 16);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nCmp++;
      if ({idleA, irA, cainA} !== {1'b1, 1'b0, a1}) begin
        nFail++; $display("[TB] FAIL frz_parked: cycle %0d got idle=%b ir=%b ain=%h expected 1 0 %h",
                          i, idleA, irA, cainA, a1);
      end
    end
    frzA = 1'b0;
    #1;
    nCmp++;
    if (irA !== 1'b1) begin
      nFail++; $display("[TB] FAIL frz_release_ready: got %b expected 1", irA);
    end
    @(negedge clk);
    ivA = 1'b0;
    nCmp++;
    if ({idleA, cainA, cbinA} !== {1'b0, a2, b2}) begin
      nFail++; $display("[TB] FAIL frz_second_accept: got idle=%b ain=%h bin=%h expected 0 %h %h",
                        idleA, cainA, cbinA, a2, b2);
    end
    w = 0;
    while (ovA !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    nCmp++;
    if ({ovA, oresA} !== {1'b1, maxOf(a2, b2)}) begin
      nFail++; $display("[TB] FAIL frz_second_result: got ov=%b res=%h expected 1 %h", ovA, oresA, maxOf(a2, b2));
    end
    orA = 1'b1;
    @(negedge clk);
    orA = 1'b0;
    expCountA++;
    nCmp++;
    if (cntA !== 4'(expCountA)) begin
      nFail++; $display("[TB] FAIL frz_second_count: got %0d expected %0d", cntA, expCountA % 16);
    end
  endtask

  // Cycle-level scoreboard for instance A. The model only knows the
  // protocol: one pair in flight, output valid two cycles after acceptance,
  // result = max, statistic = xor, counter bumps on each handoff.
  task automatic run_scoreboard(input int nHand, input int validPct, input int readyPct,
                                input int freezePct, input string tag);
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int age = 0;
    int done = 0;
    int cyc = 0;
    bit accept, hand, expOv;
    while (done < nHand && cyc < nHand * 30 + 50) begin
      expOv = (qa.size() != 0) && (age >= 2);
      nCmp++;
      if (irA !== ((qa.size() == 0) && !frzA)) begin
        nFail++; $display("[TB] FAIL %s_in_ready: cycle %0d got %b expected %b",
                          tag, cyc, irA, (qa.size() == 0) && !frzA);
      end
      nCmp++;
      if (ovA !== expOv) begin
        nFail++; $display("[TB] FAIL %s_out_valid: cycle %0d got %b expected %b", tag, cyc, ovA, expOv);
      end
      if (expOv) begin
        nCmp++;
        if ({oresA, ostatA} !== {maxOf(qa[0], qb[0]), qa[0] ^ qb[0]}) begin
          nFail++; $display("[TB] FAIL %s_data: cycle %0d got res=%h stat=%h expected %h %h",
                            tag, cyc, oresA, ostatA, maxOf(qa[0], qb[0]), qa[0] ^ qb[0]);
        end
      end
      nCmp++;
      if (cntA !== 4'(expCountA)) begin
        nFail++; $display("[TB] FAIL %s_count: cycle %0d got %0d expected %0d", tag, cyc, cntA, expCountA % 16);
      end
      ivA  = ($urandom_range(99) < validPct);
      orA  = ($urandom_range(99) < readyPct);
      frzA = ($urandom_range(99) < freezePct);
      ainA = $urandom;
      binA = $urandom;
      accept = ivA && !frzA && (qa.size() == 0);
      hand   = orA && expOv;
      if (hand) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        expCountA++;
        done++;
      end else if (qa.size() != 0) begin
        age++;
      end
      if (accept) begin
        qa.push_back(ainA);
        qb.push_back(binA);
        age = 0;
      end
      @(negedge clk);
      cyc++;
    end
    ivA = 1'b0; orA = 1'b0; frzA = 1'b0;
    nCmp++;
    if (done != nHand) begin
      nFail++; $display("[TB] FAIL %s_timeout: got %0d handoffs expected %0d", tag, done, nHand);
    end
    nCmp++;
    if (cntA !== 4'(expCountA)) begin
      nFail++; $display("[TB] FAIL %s_final_count: got %0d expected %0d", tag, cntA, expCountA % 16);
    end
  endtask

  task automatic test_random();
    run_scoreboard(25, 60, 50, 15, "random");
  endtask

  task automatic test_reset_hold();
    int w;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expCountA = 0;
    run_scoreboard(3, 100, 100, 0, "prefill");
    ainA = $urandom; binA = $urandom; ivA = 1'b1;
    @(negedge clk);
    ivA = 1'b0;
    w = 0;
    while (ovA !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    nCmp++;
    if ({ovA, cntA} !== {1'b1, 4'd3}) begin
      nFail++; $display("[TB] FAIL rsthold_setup: got ov=%b cnt=%0d expected 1 3", ovA, cntA);
    end
    rst = 1'b1; orA = 1'b1; ivA = 1'b1;
    @(negedge clk);
    rst = 1'b0; orA = 1'b0; ivA = 1'b0;
    expCountA = 0;
    expCountB = 0;
    nCmp++;
    if ({ovA, cntA, oresA, ostatA, idleA, irA, cainA} !== {1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0}) begin
      nFail++; $display("[TB] FAIL rsthold_cleared: got ov=%b cnt=%0d res=%h stat=%h idle=%b ir=%b ain=%h expected 0 0 0 0 1 1 0",
                        ovA, cntA, oresA, ostatA, idleA, irA, cainA);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expCountA = 0;
    expCountB = 0;
    run_scoreboard(17, 100, 100, 0, "b2b");
    nCmp++;
    if (cntA !== 4'd1) begin
      nFail++; $display("[TB] FAIL b2b_wrap: got %0d expected 1", cntA);
    end
  endtask

  task automatic test_latency();
    logic [31:0] a, b, c0;
    for (int t = 0; t < 3; t++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      c0 = cycB;
      ainB = a; binB = b; ivB = 1'b1; orB = 1'b0;
      @(negedge clk);
      ivB = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        nCmp++;
        if (ovB !== (k == 5)) begin
          nFail++; $display("[TB] FAIL lat_valid: txn %0d cycle %0d got %b expected %b", t, k, ovB, k == 5);
        end
      end
      nCmp++;
      if ({oresB, ostatB} !== {maxOf(a, b) + c0 + 32'd5, c0 + 32'd5}) begin
        nFail++; $display("[TB] FAIL lat_capture: txn %0d got res=%h stat=%h expected %h %h",
                          t, oresB, ostatB, maxOf(a, b) + c0 + 32'd5, c0 + 32'd5);
      end
      repeat (t) @(negedge clk);
      orB = 1'b1;
      @(negedge clk);
      orB = 1'b0;
      expCountB++;
      nCmp++;
      if ({ovB, idleB, cntB} !== {1'b0, 1'b1, 16'(expCountB)}) begin
        nFail++; $display("[TB] FAIL lat_handoff: txn %0d got ov=%b idle=%b cnt=%0d expected 0 1 %0d",
                          t, ovB, idleB, cntB, expCountB);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_freeze();
    test_random();
    test_reset_hold();
    test_back_to_back();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
